// File: rtl/proc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : proc_sequencer
//  Purpose  : Program sequencer for the 16-bit simple processor. A host loads
//             a small program memory, then `start` feeds the words one at a
//             time to the processor Run/DIN/Done interface. Each instruction
//             waits for Done under a watchdog.
//  Ports    : clk, rst (async, active-high)
//             load_en/load_addr/load_data : program memory write port
//             prog_len, start             : run control
//             proc_run, proc_din, proc_reg_rst, proc_done : processor side
//             pc, busy, finished, error, instr_count      : status
//  Revision : 1.0  initial release
// ============================================================================
module proc_sequencer #(
    parameter int N       = 16,
    parameter int DEPTH   = 16,
    parameter int AW      = 4,
    parameter int TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_en,
    input  logic [AW-1:0] load_addr,
    input  logic [N-1:0]  load_data,
    input  logic [AW:0]   prog_len,
    input  logic          start,
    output logic          proc_run,
    output logic [N-1:0]  proc_din,
    output logic          proc_reg_rst,
    input  logic          proc_done,
    output logic [AW:0]   pc,
    output logic          busy,
    output logic          finished,
    output logic          error,
    output logic [7:0]    instr_count
);

    localparam int             c_WD_W    = $clog2(TIMEOUT + 1);
    localparam logic [c_WD_W-1:0] c_WD_LAST = c_WD_W'(TIMEOUT - 1);
    localparam logic [1:0]     c_OP_MVI  = 2'b01;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ISSUE  = 3'd1,
        S_WAIT   = 3'd2,
        S_FINISH = 3'd3,
        S_ERROR  = 3'd4
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [AW:0]         r_pc, w_pc_nxt;
    logic [AW:0]         r_len, w_len_nxt;
    logic [7:0]          r_cnt, w_cnt_nxt;
    logic [c_WD_W-1:0]   r_wdog, w_wdog_nxt;
    logic                r_reg_rst, w_reg_rst_nxt;

    logic [N-1:0]        r_mem [DEPTH];
    logic                w_ready;
    logic                w_busy;
    logic [N-1:0]        w_fetch;
    logic [AW:0]         w_pc_inc;

    assign w_ready  = (r_state == S_IDLE) || (r_state == S_FINISH) ||
                      (r_state == S_ERROR);
    assign w_busy   = (r_state == S_ISSUE) || (r_state == S_WAIT);
    // The low AW bits index memory, so an immediate fetched past the last
    // word of a full-depth program wraps to word 0.
    assign w_fetch  = r_mem[r_pc[AW-1:0]];
    assign w_pc_inc = r_pc + 1'b1;

    // Program memory: no reset, writes only while not executing.
    always_ff @(posedge clk) begin
        if (load_en && w_ready) begin
            r_mem[load_addr] <= load_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_pc      <= '0;
            r_len     <= '0;
            r_cnt     <= '0;
            r_wdog    <= '0;
            r_reg_rst <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_pc      <= w_pc_nxt;
            r_len     <= w_len_nxt;
            r_cnt     <= w_cnt_nxt;
            r_wdog    <= w_wdog_nxt;
            r_reg_rst <= w_reg_rst_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_pc_nxt      = r_pc;
        w_len_nxt     = r_len;
        w_cnt_nxt     = r_cnt;
        w_wdog_nxt    = r_wdog;
        w_reg_rst_nxt = 1'b0;

        case (r_state)
            S_IDLE, S_FINISH, S_ERROR: begin
                if (start) begin
                    w_len_nxt     = prog_len;
                    w_pc_nxt      = '0;
                    w_cnt_nxt     = '0;
                    w_wdog_nxt    = '0;
                    w_reg_rst_nxt = 1'b1;
                    w_state_nxt   = (prog_len == '0) ? S_FINISH : S_ISSUE;
                end
            end
            S_ISSUE: begin
                // mvi: step pc now so WAIT presents the immediate word.
                if (w_fetch[7:6] == c_OP_MVI) begin
                    w_pc_nxt = w_pc_inc;
                end
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (proc_done) begin
                    w_pc_nxt   = w_pc_inc;
                    w_wdog_nxt = '0;
                    if (r_cnt != 8'hFF) begin
                        w_cnt_nxt = r_cnt + 8'd1;
                    end
                    w_state_nxt = (w_pc_inc >= r_len) ? S_FINISH : S_ISSUE;
                end else if (r_wdog == c_WD_LAST) begin
                    // TIMEOUT-th WAIT cycle with no Done: give up, pc frozen.
                    w_state_nxt = S_ERROR;
                end else begin
                    w_wdog_nxt = r_wdog + 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign proc_run     = (r_state == S_ISSUE);
    assign proc_din     = w_busy ? w_fetch : '0;
    assign proc_reg_rst = r_reg_rst;
    assign pc           = r_pc;
    assign busy         = w_busy;
    assign finished     = (r_state == S_FINISH);
    assign error        = (r_state == S_ERROR);
    assign instr_count  = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_proc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_proc_sequencer
//  Purpose  : Self-checking bench for proc_sequencer. Stimulus pushes the
//             expected issue words and end states into queues; a monitor
//             pops and compares whenever the DUT issues, finishes or errors.
//             A small processor model answers each Run with Done after a
//             programmable delay.
//  Revision : 1.0  initial release
// ============================================================================
module tb_proc_sequencer;

    localparam int N  = 16;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          load_en = 1'b0;
    logic [AW-1:0] load_addr = '0;
    logic [N-1:0]  load_data = '0;
    logic [AW:0]   prog_len = '0;
    logic          start = 1'b0;
    logic          proc_done = 1'b0;
    logic          proc_run;
    logic [N-1:0]  proc_din;
    logic          proc_reg_rst;
    logic [AW:0]   pc;
    logic          busy;
    logic          finished;
    logic          error;
    logic [7:0]    instr_count;

    proc_sequencer #(.N(N), .DEPTH(16), .AW(AW), .TIMEOUT(15)) dut (
        .clk          (clk),
        .rst          (rst),
        .load_en      (load_en),
        .load_addr    (load_addr),
        .load_data    (load_data),
        .prog_len     (prog_len),
        .start        (start),
        .proc_run     (proc_run),
        .proc_din     (proc_din),
        .proc_reg_rst (proc_reg_rst),
        .proc_done    (proc_done),
        .pc           (pc),
        .busy         (busy),
        .finished     (finished),
        .error        (error),
        .instr_count  (instr_count)
    );

    always #5 clk = ~clk;

    typedef struct { logic [N-1:0] run_din; logic [N-1:0] wait_din; } iss_t;
    typedef struct { logic [AW:0] pc; logic [7:0] cnt; } end_t;

    iss_t iss_q[$];
    end_t fin_q[$];
    end_t err_q[$];
    int   dly_q[$];

    int   n_checks = 0;
    int   n_fail   = 0;
    logic model_on = 1'b1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_iss(input logic [N-1:0] r, input logic [N-1:0] w);
        iss_t e;
        e.run_din = r; e.wait_din = w;
        iss_q.push_back(e);
    endtask

    task automatic push_fin(input int p, input int c);
        end_t e;
        e.pc = (AW+1)'(p); e.cnt = 8'(c);
        fin_q.push_back(e);
    endtask

    task automatic push_err(input int p, input int c);
        end_t e;
        e.pc = (AW+1)'(p); e.cnt = 8'(c);
        err_q.push_back(e);
    endtask

    // mvi R0,#5 ; mv R1,R0
    task automatic push_main();
        push_iss(16'h0040, 16'h0005);
        push_iss(16'h0008, 16'h0008);
        push_fin(3, 2);
    endtask

    task automatic load_word(input int a, input int d);
        load_en = 1'b1; load_addr = AW'(a); load_data = N'(d);
        @(negedge clk);
        load_en = 1'b0;
    endtask

    // Returns at the negedge of the cycle after the start edge.
    task automatic do_start(input int len);
        prog_len = (AW+1)'(len); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_end(output int n);
        n = 0;
        for (int i = 1; i <= 300; i++) begin
            @(negedge clk);
            if (finished || error) begin
                n = i;
                break;
            end
        end
        if (n == 0) begin
            n_checks++; n_fail++;
            $display("FAIL end_timeout: no finished/error within 300 cycles");
        end
    endtask

    // ---------------- processor model ----------------
    int m_d;
    initial begin
        forever begin
            @(negedge clk);
            while (proc_run && model_on) begin
                m_d = (dly_q.size() > 0) ? dly_q.pop_front() : 2;
                repeat (m_d) @(negedge clk);
                proc_done = 1'b1;
                @(negedge clk);
                proc_done = 1'b0;
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    iss_t         mon_e;
    end_t         mon_f;
    logic [N-1:0] cur_wait = '0;
    logic         prev_run = 1'b0;
    logic         prev_fin = 1'b0;
    logic         prev_err = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            prev_run = 1'b0; prev_fin = 1'b0; prev_err = 1'b0;
        end else begin
            if (proc_run) begin
                chk("run_back_to_back", 32'(prev_run), 32'd0);
                if (iss_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL unexpected_run: din %0h with nothing expected", proc_din);
                end else begin
                    mon_e = iss_q.pop_front();
                    chk("issue_din", 32'(proc_din), 32'(mon_e.run_din));
                    cur_wait = mon_e.wait_din;
                end
            end else if (busy) begin
                chk("wait_din", 32'(proc_din), 32'(cur_wait));
            end
            if (finished && !prev_fin) begin
                if (fin_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL unexpected_finish: pc %0d count %0d", pc, instr_count);
                end else begin
                    mon_f = fin_q.pop_front();
                    chk("finish_pc", 32'(pc), 32'(mon_f.pc));
                    chk("finish_count", 32'(instr_count), 32'(mon_f.cnt));
                end
            end
            if (error && !prev_err) begin
                if (err_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL unexpected_error: pc %0d", pc);
                end else begin
                    mon_f = err_q.pop_front();
                    chk("error_pc", 32'(pc), 32'(mon_f.pc));
                    chk("error_count", 32'(instr_count), 32'(mon_f.cnt));
                    chk("error_busy", 32'(busy), 32'd0);
                end
            end
            prev_run = proc_run; prev_fin = finished; prev_err = error;
        end
    end

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_run"},      32'(proc_run),     32'd0);
        chk({tag, "_din"},      32'(proc_din),     32'd0);
        chk({tag, "_reg_rst"},  32'(proc_reg_rst), 32'd0);
        chk({tag, "_pc"},       32'(pc),           32'd0);
        chk({tag, "_busy"},     32'(busy),         32'd0);
        chk({tag, "_finished"}, 32'(finished),     32'd0);
        chk({tag, "_error"},    32'(error),        32'd0);
        chk({tag, "_count"},    32'(instr_count),  32'd0);
    endtask

    // ---------------- stimulus ----------------
    int n;
    int runs;

    initial begin
        @(negedge clk);
        chk_reset_vals("reset");
        rst = 1'b0;
        @(negedge clk);

        load_word(0, 16'h0040);
        load_word(1, 16'h0005);
        load_word(2, 16'h0008);

        // Empty program: straight to FINISH, reg_rst pulse still issued.
        push_fin(0, 0);
        do_start(0);
        chk("len0_reg_rst", 32'(proc_reg_rst), 32'd1);
        chk("len0_run", 32'(proc_run), 32'd0);
        chk("len0_finished", 32'(finished), 32'd1);
        chk("len0_busy", 32'(busy), 32'd0);
        @(negedge clk);
        chk("len0_reg_rst_drop", 32'(proc_reg_rst), 32'd0);

        // Main program, Done two cycles after each Run.
        push_main();
        dly_q = '{2, 2};
        do_start(3);
        chk("start_reg_rst", 32'(proc_reg_rst), 32'd1);
        chk("start_run", 32'(proc_run), 32'd1);
        chk("start_busy", 32'(busy), 32'd1);
        wait_end(n);
        chk("main_latency", 32'(n), 32'd6);

        // Varying processor latency.
        for (int k = 0; k < 3; k++) begin
            push_main();
            case (k)
                0: dly_q = '{1, 10};
                1: dly_q = '{10, 1};
                default: dly_q = '{5, 3};
            endcase
            do_start(3);
            wait_end(n);
        end

        // mvi at the last address: immediate is mem[1], pc ends at len+1.
        push_iss(16'h0040, 16'h0005);
        push_fin(2, 1);
        do_start(1);
        wait_end(n);

        // Write attempt while busy is dropped; a rerun still sees 0x0008.
        push_main();
        do_start(3);
        load_word(2, 16'hFFFF);
        wait_end(n);
        push_main();
        do_start(3);
        wait_end(n);

        // Write and start together: first fetch sees the new word.
        push_iss(16'h0010, 16'h0010);
        push_iss(16'h0005, 16'h0005);
        push_iss(16'h0008, 16'h0008);
        push_fin(3, 3);
        load_en = 1'b1; load_addr = '0; load_data = 16'h0010;
        do_start(3);
        load_en = 1'b0;
        wait_end(n);
        load_word(0, 16'h0081);

        // Watchdog: processor never answers.
        model_on = 1'b0;
        push_iss(16'h0081, 16'h0081);
        push_err(0, 0);
        do_start(1);
        wait_end(n);
        chk("wdog_latency", 32'(n), 32'd16);
        chk("wdog_error", 32'(error), 32'd1);
        model_on = 1'b1;
        load_word(0, 16'h0040);
        push_main();
        do_start(3);
        wait_end(n);

        // Async reset during WAIT of the second instruction.
        push_iss(16'h0040, 16'h0005);
        push_iss(16'h0008, 16'h0008);
        dly_q = '{2, 8};
        do_start(3);
        runs = 1;
        for (int i = 0; i < 50 && runs < 2; i++) begin
            @(negedge clk);
            if (proc_run) runs++;
        end
        chk("second_run_seen", 32'(runs), 32'd2);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk_reset_vals("midrst");
        @(negedge clk);
        rst = 1'b0;
        // The abandoned Done arrives while IDLE and must change nothing.
        repeat (12) @(negedge clk);
        chk("stray_pc", 32'(pc), 32'd0);
        chk("stray_count", 32'(instr_count), 32'd0);
        chk("stray_busy", 32'(busy), 32'd0);
        chk("stray_finished", 32'(finished), 32'd0);
        push_main();
        do_start(3);
        chk("rerun_pc", 32'(pc), 32'd0);
        chk("rerun_count", 32'(instr_count), 32'd0);
        wait_end(n);

        repeat (3) @(negedge clk);
        chk("iss_q_drained", 32'(iss_q.size()), 32'd0);
        chk("fin_q_drained", 32'(fin_q.size()), 32'd0);
        chk("err_q_drained", 32'(err_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/proc_sequencer.md
# proc_sequencer

Program sequencer for the 16-bit simple processor. It holds a small program memory loaded by a host, then feeds instructions and immediate words to the processor's `Run`/`DIN`/`Done` interface one at a time. For every instruction it waits for `Done`, and it enforces a watchdog on the processor. It sits between the host/test logic and the processor top level, replacing manual switch-driven `Run`/`DIN` control.

## Interface
- `N`, 16: processor data width; `DIN` and program words are N bits.
- `DEPTH`, 16: program memory words (power of two).
- `AW`, 4: address width, log2(DEPTH).
- `TIMEOUT`, 15: max cycles from `Run` pulse to `Done` before error.

Ports:
- `clk`  in  1  single system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `load_en`  in  1  write `load_data` to `mem[load_addr]`; honored only in IDLE/FINISH/ERROR.
- `load_addr`  in  AW  program write address.
- `load_data`  in  N  program word.
- `prog_len`  in  AW+1  number of words to execute (0..DEPTH); sampled on `start`.
- `start`  in  1  begin execution at address 0; ignored unless IDLE/FINISH/ERROR.
- `proc_run`  out  1  to processor `Run`.
- `proc_din`  out  N  to processor `DIN`.
- `proc_reg_rst`  out  1  to processor `reg_rst`, one-cycle pulse on `start`.
- `proc_done`  in  1  from processor `Done`.
- `pc`  out  AW+1  address of the current/next word.
- `busy`  out  1  high in ISSUE/WAIT.
- `finished`  out  1  high in FINISH.
- `error`  out  1  high in ERROR (watchdog expired).
- `instr_count`  out  8  instructions completed since last `start`, saturating at 255.

## Operation
- Instruction word encoding in `[7:0]`:
  - `[7:6]` op: 00 mv, 01 mvi, 10 add, 11 sub.
  - `[5:3]` X, `[2:0]` Y.
  - `[N-1:8]` ignored.
- mvi consumes the next memory word as its immediate.
- States: IDLE, ISSUE, WAIT, FINISH, ERROR.
- IDLE/FINISH/ERROR + `start`:
  - latch `prog_len`, set `pc`=0, clear `instr_count` and watchdog.
  - pulse `proc_reg_rst`.
  - go to ISSUE, or to FINISH if `prog_len`=0.
- ISSUE (one cycle):
  - `proc_run`=1, `proc_din`=`mem[pc]`.
  - latch `is_mvi` = (op==01).
  - If `is_mvi`, `pc`+=1; otherwise `pc` unchanged.
  - Go to WAIT.
- WAIT:
  - `proc_run`=0.
  - `proc_din`=`mem[pc]` (the immediate for mvi; the same instruction otherwise).
  - Watchdog increments every cycle.
  - On `proc_done`: `pc`+=1, `instr_count`+=1, watchdog cleared. Then go to FINISH if new `pc`>=latched `prog_len`, else ISSUE.
  - If the watchdog reaches `TIMEOUT` without `proc_done`: go to ERROR, `pc` frozen.
- mvi at the last address (`pc`+1 == `prog_len`):
  - The immediate reads `mem[prog_len]`, or wraps to `mem[0]` when `prog_len`=DEPTH.
  - Completion then sets `pc`=`prog_len`+1 and the block enters FINISH.
- `proc_done` outside WAIT is ignored.
- `load_en` during ISSUE/WAIT is ignored; memory is unchanged.
- `start` and `load_en` in the same cycle: the write occurs and execution starts. The first fetch uses the updated word if addresses match.
- FINISH and ERROR hold until the next `start`.

## Timing
- Reset (async, immediate) puts the block in IDLE with:
  - `proc_run`=0, `proc_din`=0, `proc_reg_rst`=0.
  - `pc`=0, `busy`=0, `finished`=0, `error`=0, `instr_count`=0.
- Program memory is not reset.
- All outputs are registered or decoded from state; no combinational path from `proc_done` to any output.
- Memory write: synchronous; readable in the next cycle.
- `start` at edge k:
  - `proc_reg_rst` high during cycle k+1 (the ISSUE cycle).
  - `proc_run` high during cycle k+1.
- Rate limits:
  - `proc_run` is never high on consecutive cycles.
  - `proc_run` is at most once per instruction.
- `proc_done` sampled at edge m in WAIT gives:
  - next ISSUE (`proc_run`=1) in cycle m+1;
  - or FINISH visible in cycle m+1.
- Minimum instruction period: 2 cycles of sequencer overhead plus processor latency.
- Watchdog: ERROR entered at the edge where WAIT has lasted `TIMEOUT` cycles without `proc_done`.
- `rst` mid-execution: returns to IDLE at once; a processor in mid-instruction is abandoned.

## Test plan
- Load `mem[0]`=0x0040 (mvi R0), `mem[1]`=0x0005, `mem[2]`=0x0008 (mv R1,R0), `prog_len`=3, `start`; model processor returns `proc_done` 2 cycles after ISSUE -> two `proc_run` pulses, `proc_din`=0x0005 during the first WAIT, FINISH with `pc`=3, `instr_count`=2.
- Same program, processor Done delays varying 1..10 cycles -> no `proc_run` while in WAIT, `proc_din` stable throughout each WAIT, identical final counts.
- Processor never asserts `proc_done`, `TIMEOUT`=15 -> `error`=1 exactly 15 WAIT cycles after the first ISSUE, `pc`=0, `busy`=0; a new `start` recovers.
- `prog_len`=0, `start` -> no `proc_run`, `finished`=1 next cycle, `proc_reg_rst` pulse still seen.
- `load_en` while busy writing `mem[2]`=0xFFFF -> readback after FINISH shows the original 0x0008; a stray `proc_done` in IDLE changes nothing.
- Assert `rst` in WAIT of the second instruction -> same cycle: all outputs take reset values; next `start` reruns from `pc`=0 with `instr_count` cleared.
